// File: rtl/mcu_dp_pkg.sv
// Shared constants for the MCU datapath blocks: selector modes, default data width
// and the round-robin pointer wrap helper.
package mcu_dp_pkg;

   localparam int MODE_SEL = 0;
   localparam int MODE_RR  = 1;
   localparam int DATA_W   = 32;

   // Channel index after idx, wrapping back to 0 past the last of n channels.
   function automatic int rr_wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_n_1_hs_if.sv
// Handshake bundle between N producers, the selector and its single consumer.
// The selector takes the slave view; the producer/consumer side takes the master view.
interface mux_n_1_hs_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4
);
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [SEL_W-1:0]   sel;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_chan;
   logic               out_valid;
   logic               out_ready;

   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel found
// when scanning from ptr_i upwards, wrapping from N-1 back to 0.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic             grant_vld_o,
   output logic [SEL_W-1:0] grant_idx_o
);

   int idx;

   always_comb begin
      grant_vld_o = 1'b0;
      grant_idx_o = '0;
      idx         = 0;
      // ptr_i is always below N, so a single subtraction folds the scan back into range.
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!grant_vld_o && req_i[idx]) begin
            grant_vld_o = 1'b1;
            grant_idx_o = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mux_n_1_hs.sv
// N-to-1 handshake selector with a registered output word; the channel comes either
// from an external select or from a round-robin arbiter over the valid inputs.
module mux_n_1_hs
   import mcu_dp_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int N     = 4,
   parameter int MODE  = MODE_SEL
) (
   input  logic         clk,
   input  logic         rst,
   mux_n_1_hs_if.slave  bus
);

   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

   logic             can_load;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [N-1:0]     ready;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_chan_q,  out_chan_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   assign can_load = !out_valid_q || bus.out_ready;

   generate
      if (MODE == MODE_RR) begin : g_rr
         rr_arbiter #(
            .N     (N),
            .SEL_W (SEL_W)
         ) u_arb (
            .req_i       (bus.in_valid),
            .ptr_i       (ptr_q),
            .grant_vld_o (grant_vld),
            .grant_idx_o (grant_idx)
         );
      end else begin : g_sel
         // A select value that names no channel (possible when N is not a power of two) grants nothing.
         assign grant_vld = (int'(bus.sel) < N);
         assign grant_idx = bus.sel;
      end
   endgenerate

   always_comb begin
      ready = '0;
      if (!rst && grant_vld && can_load) begin
         ready[grant_idx] = 1'b1;
      end
   end

   assign xfer = |(ready & bus.in_valid);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            sel_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_chan_d  = grant_idx;
         if (MODE == MODE_RR) begin
            ptr_d = SEL_W'(rr_wrap_inc(int'(grant_idx), N));
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_n_1_hs.sv
// Directed bench: select mode at N=4/6/3 and round-robin mode at N=4, driven from
// a vector table plus hand-written multi-cycle sequences.
module tb_mux_n_1_hs;
   import mcu_dp_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   mux_n_1_hs_if #(.WIDTH(32), .N(4)) ia ();
   mux_n_1_hs_if #(.WIDTH(32), .N(4)) ib ();
   mux_n_1_hs_if #(.WIDTH(32), .N(6)) ic ();
   mux_n_1_hs_if #(.WIDTH(32), .N(3)) id ();

   mux_n_1_hs #(.WIDTH(32), .N(4), .MODE(MODE_SEL)) u_sel4 (.clk(clk), .rst(rst), .bus(ia.slave));
   mux_n_1_hs #(.WIDTH(32), .N(4), .MODE(MODE_RR))  u_rr4  (.clk(clk), .rst(rst), .bus(ib.slave));
   mux_n_1_hs #(.WIDTH(32), .N(6), .MODE(MODE_SEL)) u_sel6 (.clk(clk), .rst(rst), .bus(ic.slave));
   mux_n_1_hs #(.WIDTH(32), .N(3), .MODE(MODE_SEL)) u_sel3 (.clk(clk), .rst(rst), .bus(id.slave));

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic        ordy;
      logic [3:0]  rdy;
      logic        ov;
      logic [31:0] dat;
      logic [1:0]  ch;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ia.in_data = {32'hC3C3C3C3, 32'hDEADBEEF, 32'hB1B1B1B1, 32'hA0A0A0A0};
      ib.in_data = {32'h00000103, 32'h00000102, 32'h00000101, 32'h00000100};
      for (int i = 0; i < 6; i++) ic.in_data[i*32 +: 32] = 32'hC0000000 + 32'(i);
      for (int i = 0; i < 3; i++) id.in_data[i*32 +: 32] = 32'hD0000000 + 32'(i);
      ia.sel = 2'd0; ib.sel = 2'd0; ic.sel = 3'd0; id.sel = 2'd0;
      ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1; id.out_ready = 1'b1;

      tbl[0] = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
      tbl[1] = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'hB1B1B1B1, 2'd1};
      tbl[2] = '{2'd3, 4'b0000, 1'b1, 4'b1000, 1'b0, 32'hB1B1B1B1, 2'd1};
      tbl[3] = '{2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'hA0A0A0A0, 2'd0};
      tbl[4] = '{2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 32'hA0A0A0A0, 2'd0};
      tbl[5] = '{2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 32'hC3C3C3C3, 2'd3};
      tbl[6] = '{2'd2, 4'b0001, 1'b1, 4'b0100, 1'b0, 32'hC3C3C3C3, 2'd3};
      tbl[7] = '{2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'hA0A0A0A0, 2'd0};

      // Reset held two cycles with every input valid
      rst = 1'b1;
      ia.in_valid = 4'hF; ib.in_valid = 4'hF; ic.in_valid = 6'h3F; id.in_valid = 3'h7;
      #1;
      chk("rst_rdy_sel", 64'(ia.in_ready), 64'h0);
      chk("rst_rdy_rr", 64'(ib.in_ready), 64'h0);
      tick();
      tick();
      chk("rst_ov_sel", 64'(ia.out_valid), 64'h0);
      chk("rst_dat_sel", 64'(ia.out_data), 64'h0);
      chk("rst_ov_rr", 64'(ib.out_valid), 64'h0);
      chk("rst_chan_rr", 64'(ib.out_chan), 64'h0);
      chk("rst_rdy_rr2", 64'(ib.in_ready), 64'h0);
      rst = 1'b0;
      ia.in_valid = '0; ib.in_valid = '0; ic.in_valid = '0; id.in_valid = '0;

      // Select-mode vector table
      for (int v = 0; v < 8; v++) begin
         ia.sel = tbl[v].sel; ia.in_valid = tbl[v].vld; ia.out_ready = tbl[v].ordy;
         #1;
         chk($sformatf("tbl%0d_rdy", v), 64'(ia.in_ready), 64'(tbl[v].rdy));
         tick();
         chk($sformatf("tbl%0d_ov", v), 64'(ia.out_valid), 64'(tbl[v].ov));
         chk($sformatf("tbl%0d_dat", v), 64'(ia.out_data), 64'(tbl[v].dat));
         chk($sformatf("tbl%0d_ch", v), 64'(ia.out_chan), 64'(tbl[v].ch));
      end

      // Backpressure: hold a word five cycles, then replace it with no bubble
      ia.sel = 2'd1; ia.in_valid = 4'b0000; ia.out_ready = 1'b1;
      tick();
      chk("bp_drain_ov", 64'(ia.out_valid), 64'h0);
      ia.in_valid = 4'b0010; ia.out_ready = 1'b0;
      tick();
      chk("bp_load_dat", 64'(ia.out_data), 64'hB1B1B1B1);
      ia.sel = 2'd2; ia.in_valid = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp_stall%0d_rdy", c), 64'(ia.in_ready), 64'h0);
         tick();
         chk($sformatf("bp_stall%0d_dat", c), 64'(ia.out_data), 64'hB1B1B1B1);
         chk($sformatf("bp_stall%0d_ov", c), 64'(ia.out_valid), 64'h1);
      end
      ia.out_ready = 1'b1;
      #1;
      chk("bp_rel_rdy", 64'(ia.in_ready), 64'b0100);
      tick();
      chk("bp_rel_dat", 64'(ia.out_data), 64'hDEADBEEF);
      chk("bp_rel_ch", 64'(ia.out_chan), 64'd2);
      chk("bp_rel_ov", 64'(ia.out_valid), 64'h1);

      // Mid-transfer reset discards the held word
      ia.out_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_ov_sel", 64'(ia.out_valid), 64'h0);
      chk("mrst_dat_sel", 64'(ia.out_data), 64'h0);
      ia.in_valid = '0;

      // Round-robin with all channels valid: 0,1,2,3,0,1
      ib.in_valid = 4'hF; ib.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr%0d_rdy", k), 64'(ib.in_ready), 64'(4'b0001 << (k % 4)));
         tick();
         chk($sformatf("rr%0d_ch", k), 64'(ib.out_chan), 64'(k % 4));
         chk($sformatf("rr%0d_dat", k), 64'(ib.out_data), 64'(32'h100 + 32'(k % 4)));
         chk($sformatf("rr%0d_ov", k), 64'(ib.out_valid), 64'h1);
      end

      // Reset mid-stream clears the pointer, then 4'b1001 from ptr=1 grants 3 then wraps to 0
      rst = 1'b1;
      #1;
      chk("rr_rst_rdy", 64'(ib.in_ready), 64'h0);
      tick();
      rst = 1'b0;
      chk("rr_rst_ov", 64'(ib.out_valid), 64'h0);
      tick();
      chk("rr_ptr0_ch", 64'(ib.out_chan), 64'd0);
      ib.in_valid = 4'b1001;
      #1;
      chk("rr_wrap_rdy3", 64'(ib.in_ready), 64'b1000);
      tick();
      chk("rr_wrap_ch3", 64'(ib.out_chan), 64'd3);
      #1;
      chk("rr_wrap_rdy0", 64'(ib.in_ready), 64'b0001);
      tick();
      chk("rr_wrap_ch0", 64'(ib.out_chan), 64'd0);
      ib.in_valid = '0;

      // N=6: sel=5 is a real channel, sel=6 is not
      ic.sel = 3'd5; ic.in_valid = 6'b100000; ic.out_ready = 1'b1;
      #1;
      chk("n6_sel5_rdy", 64'(ic.in_ready), 64'b100000);
      tick();
      chk("n6_sel5_ch", 64'(ic.out_chan), 64'd5);
      chk("n6_sel5_dat", 64'(ic.out_data), 64'hC0000005);
      ic.sel = 3'd6; ic.in_valid = 6'h3F;
      #1;
      chk("n6_sel6_rdy", 64'(ic.in_ready), 64'h0);
      tick();
      chk("n6_sel6_ov", 64'(ic.out_valid), 64'h0);

      // N=3: sel=3 is out of range, sel=2 is the top channel
      id.sel = 2'd3; id.in_valid = 3'b111; id.out_ready = 1'b1;
      #1;
      chk("n3_sel3_rdy", 64'(id.in_ready), 64'h0);
      tick();
      chk("n3_sel3_ov", 64'(id.out_valid), 64'h0);
      id.sel = 2'd2;
      #1;
      chk("n3_sel2_rdy", 64'(id.in_ready), 64'b100);
      tick();
      chk("n3_sel2_ch", 64'(id.out_chan), 64'd2);
      chk("n3_sel2_dat", 64'(id.out_data), 64'hD0000002);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
